seq_detect_prog: RTL and testbench

- Runtime-programmable serial bit-pattern detector. It is the parametrised successor of the fixed 3-bit "001" Mealy detector.
- Supports patterns of 1..MAX_LEN bits, an overlapping or non-overlapping match mode, an input-valid qualifier, and a saturating match counter.
- Sits on serial control/data lines. After reset, the default configuration behaves exactly like the legacy "001" detector.

---
 rtl/seq_detect_prog.sv | 127 ++++++++++++
 tb/tb_seq_detect_prog.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector with saturating match counter.
// Define SEQ_DETECT_REG_OUT_EN to register det (one-cycle-late, glitch-free pulse).
module seq_detect_prog #(
    parameter int unsigned          MAX_LEN = 8,
    parameter int unsigned          CNT_W   = 8,
    parameter logic [MAX_LEN-1:0]   RST_PAT = MAX_LEN'(8'b0000_0001),
    parameter int unsigned          RST_LEN = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cfg_we,
    input  logic [MAX_LEN-1:0]                 cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]       cfg_len,
    input  logic                               cfg_overlap,
    input  logic                               in_valid,
    input  logic                               in_bit,
    input  logic                               cnt_clr,
    output logic                               det,
    output logic [CNT_W-1:0]                   match_count,
    output logic                               cnt_sat
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    // The oldest history bit is never compared, so only MAX_LEN-1 bits are kept.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_pat;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cnt_sat;

    logic [MAX_LEN-1:0] w_cand;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_fill_ok;
    logic               w_hit;
    logic [LEN_W-1:0]   w_len_ld;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign w_cand = {r_hist, in_bit};

    // Select the low r_len bits of the candidate window.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < 32'(r_len));
        end
    end

    assign w_fill_ok = ((LEN_W+1)'(r_fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(r_len);

    assign w_hit = ~reset & in_valid & ~cfg_we & (r_len != '0) & w_fill_ok
                 & (((w_cand ^ r_pat) & w_mask) == '0);

    assign w_len_ld = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    // Non-overlap restarts the fill count so the next match needs len fresh bits.
    always_comb begin
        w_fill_nxt = r_fill;
        if (w_hit && !r_overlap) begin
            w_fill_nxt = '0;
        end else if (r_fill != LEN_W'(MAX_LEN)) begin
            w_fill_nxt = r_fill + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= RST_PAT;
            r_len     <= LEN_W'(RST_LEN);
            r_overlap <= 1'b1;
        end else if (cfg_we) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= cfg_pattern;
            r_len     <= w_len_ld;
            r_overlap <= cfg_overlap;
        end else if (in_valid) begin
            r_hist    <= w_cand[MAX_LEN-2:0];
            r_fill    <= w_fill_nxt;
        end
    end

    // Clear has priority over a simultaneous hit; the counter sticks at all-ones.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (cnt_clr) begin
            w_cnt_nxt = '0;
        end else if (w_hit && !(&r_cnt)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_cnt_sat <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_cnt_sat <= &w_cnt_nxt;
        end
    end

    assign match_count = r_cnt;
    assign cnt_sat     = r_cnt_sat;

`ifdef SEQ_DETECT_REG_OUT_EN
    logic r_det;

    always_ff @(posedge clk) begin
        if (reset || cfg_we) begin
            r_det <= 1'b0;
        end else begin
            r_det <= w_hit;
        end
    end

    assign det = r_det;
`else
    assign det = w_hit;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog (combinational det build).
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_seq_detect_prog;

    logic       clk;
    logic       reset;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       in_valid;
    logic       in_bit;
    logic       cnt_clr;
    logic       det;
    logic [7:0] match_count;
    logic       cnt_sat;
    logic       det2;
    logic [1:0] match_count2;
    logic       cnt_sat2;

    int checks = 0;
    int errors = 0;
    int step   = 0;
    string phase = "reset";

    seq_detect_prog u_dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cnt_clr     (cnt_clr),
        .det         (det),
        .match_count (match_count),
        .cnt_sat     (cnt_sat)
    );

    seq_detect_prog #(.CNT_W(2)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cnt_clr     (cnt_clr),
        .det         (det2),
        .match_count (match_count2),
        .cnt_sat     (cnt_sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%0d %s observed=%0h expected=%0h", phase, step, tag, obs, exp);
        end
    endtask

    // Present one bit from the falling edge and check det before the next rising edge.
    task automatic send(input logic v, input logic b, input logic exp_det, input logic clr);
        @(negedge clk);
        reset    = 1'b0;
        cfg_we   = 1'b0;
        in_valid = v;
        in_bit   = b;
        cnt_clr  = clr;
        step++;
        #1;
        chk("det", 32'(det), 32'(exp_det));
    endtask

    task automatic idle_chk(input int exp_cnt, input int exp_cnt2, input logic exp_sat2);
        @(negedge clk);
        reset    = 1'b0;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        #1;
        chk("match_count", 32'(match_count), 32'(exp_cnt));
        chk("match_count_w2", 32'(match_count2), 32'(exp_cnt2));
        chk("cnt_sat_w2", 32'(cnt_sat2), 32'(exp_sat2));
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        @(negedge clk);
        reset       = 1'b0;
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        in_valid    = 1'b0;
        cnt_clr     = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        cnt_clr     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_det", 32'(det), 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
        chk("rst_sat", 32'(cnt_sat), 32'd0);
        chk("rst_count_w2", 32'(match_count2), 32'd0);

        // Default "001", overlap: hits on 4th and 8th bits.
        phase = "default_001";
        send(1, 1, 0, 0); send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 1, 1, 0);
        send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 1, 1, 0);
        idle_chk(2, 2, 0);

        phase = "p1010_overlap";
        load(8'b0000_1010, 4'd4, 1'b1);
        send(1, 1, 0, 0); send(1, 0, 0, 0); send(1, 1, 0, 0);
        send(1, 0, 1, 0); send(1, 1, 0, 0); send(1, 0, 1, 0);
        idle_chk(4, 3, 1);

        phase = "p1010_nonoverlap";
        load(8'b0000_1010, 4'd4, 1'b0);
        send(1, 1, 0, 0); send(1, 0, 0, 0); send(1, 1, 0, 0);
        send(1, 0, 1, 0); send(1, 1, 0, 0); send(1, 0, 0, 0);
        idle_chk(5, 3, 1);

        // in_valid gaps with the bit held: same matches, det only on valid cycles.
        phase = "valid_gaps";
        load(8'b0000_0001, 4'd3, 1'b1);
        send(1, 1, 0, 0); send(0, 1, 0, 0);
        send(1, 0, 0, 0); send(0, 0, 0, 0);
        send(1, 0, 0, 0); send(0, 0, 0, 0);
        send(1, 1, 1, 0); send(0, 1, 0, 0);
        send(1, 0, 0, 0); send(0, 0, 0, 0);
        send(1, 0, 0, 0); send(0, 0, 0, 0);
        send(1, 0, 0, 0); send(0, 0, 0, 0);
        send(1, 1, 1, 0); send(0, 1, 0, 0);
        idle_chk(7, 3, 1);

        phase = "saturate";
        @(negedge clk);
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        idle_chk(0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 1, 1, 0);
            idle_chk(k, (k < 3) ? k : 3, (k >= 3));
        end
        send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 1, 1, 1);
        idle_chk(0, 0, 0);

        // A config load mid-pattern drops the presented bit and the partial match.
        phase = "cfg_mid_stream";
        send(1, 0, 0, 0); send(1, 0, 0, 0);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_pattern = 8'b0000_0001;
        cfg_len     = 4'd3;
        cfg_overlap = 1'b1;
        in_valid    = 1'b1;
        in_bit      = 1'b1;
        step++;
        #1;
        chk("det_on_cfg_we", 32'(det), 32'd0);
        send(1, 1, 0, 0);
        idle_chk(0, 0, 0);

        phase = "reset_mid_stream";
        send(1, 0, 0, 0); send(1, 0, 0, 0);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        send(1, 1, 0, 0);
        idle_chk(0, 0, 0);

        phase = "len0";
        load(8'b0000_0001, 4'd0, 1'b1);
        send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 1, 0, 0);
        send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 1, 0, 0);
        idle_chk(0, 0, 0);

        // cfg_len=15 clamps to 8; 0xA5 hits only once all 8 bits are in.
        phase = "len_clamp_a5";
        load(8'hA5, 4'd15, 1'b1);
        send(1, 1, 0, 0); send(1, 0, 0, 0); send(1, 1, 0, 0); send(1, 0, 0, 0);
        send(1, 0, 0, 0); send(1, 1, 0, 0); send(1, 0, 0, 0); send(1, 1, 1, 0);
        idle_chk(1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
